matmul_tile_ctrl: RTL and testbench
===================================

Name: matmul_tile_ctrl

Overview:
- Sequencer that computes a DIM x DIM signed matrix product by time-sharing one 2x2 engine (one 2x2 x 2x2 product per start/done transaction).
- Holds local A, B and C buffers: the host loads A and B, issues a command, then reads C back.
- Iterates over output tiles and K-tiles, feeds operand tiles to the engine and accumulates the partial products into C.
- Sits between the host-side register/AXI front end and the 2x2 engine.

Parameters:
- DATA_W, 8, signed operand width.
- ACC_W, 32, signed accumulator / result width.
- DIM, 4, matrix dimension; must be even, 2..8.
- IDX_W, $clog2(DIM), row/column index width.

Ports:
- clk  in  1  clock, all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_sel  in  1  write target: 0 = A buffer, 1 = B buffer.
- wr_row  in  IDX_W  write row index.
- wr_col  in  IDX_W  write column index.
- wr_data  in  DATA_W  signed write data.
- rd_row  in  IDX_W  C read row index.
- rd_col  in  IDX_W  C read column index.
- rd_data  out  ACC_W  C[rd_row][rd_col], combinational read.
- cmd_valid  in  1  request to run a multiply.
- cmd_ready  out  1  high only in IDLE.
- busy  out  1  high from command accept until the DONE cycle, inclusive.
- done  out  1  one-cycle pulse when C is complete.
- eng_start  out  1  one-cycle engine start pulse.
- eng_A  out  signed [DATA_W] x [2][2]  A operand tile.
- eng_B  out  signed [DATA_W] x [2][2]  B operand tile.
- eng_C  in  signed [ACC_W] x [2][2]  engine product, valid while eng_done is high.
- eng_done  in  1  one-cycle engine completion pulse.

Behaviour:
- Reset (async, active-low):
  - State = IDLE.
  - A, B and C buffers all cleared to 0.
  - eng_A, eng_B = 0; eng_start = 0; done = 0; busy = 0; cmd_ready = 1.
  - Tile indices ti, tj, tk = 0.
  - A reset asserted mid-operation aborts immediately. No engine handshake is completed afterwards; any eng_done arriving after reset release is ignored.
- T = DIM/2 tiles per dimension; total engine operations per command = T^3 (8 for DIM=4).
- States and transitions:
  - IDLE -> ISSUE: on cmd_valid && cmd_ready. Clear ti, tj, tk. Register the operand tiles into eng_A/eng_B on that same edge.
  - ISSUE (exactly 1 cycle) -> WAIT:
    - eng_start = 1.
    - eng_A = A[2ti..2ti+1][2tk..2tk+1].
    - eng_B = B[2tk..2tk+1][2tj..2tj+1].
  - WAIT: eng_A/eng_B held stable; eng_done is sampled only in this state. On eng_done:
    - tk == 0: write C tile (ti,tj) = eng_C (overwrite, so earlier results never leak in).
    - tk > 0: C tile += eng_C, element-wise, wrapping modulo 2^ACC_W.
    - Advance the indices, tk innermost, then tj, then ti.
    - If more operations remain -> ISSUE, loading the next operands on the same edge. Otherwise -> DONE.
  - DONE (1 cycle): done = 1, busy = 1 -> IDLE.
- Timing: if the engine raises eng_done N >= 1 cycles after its eng_start cycle, each operation takes N+1 cycles. done is high exactly T^3*(N+1)+1 cycles after the accept cycle.
- eng_done in IDLE, ISSUE or DONE: ignored.
- cmd_valid while busy: not accepted (cmd_ready = 0), no side effects.
- A command is accepted in the cycle right after DONE if cmd_valid is held high.
- wr_en while busy: ignored; buffers are unchanged.
- wr_en in IDLE: written on the next edge. A write and a cmd accept in the same IDLE cycle: the write lands and is visible to the command, because operand registers sample the buffer after the write.
- rd_data is valid at any time. During busy it shows partial sums.

Test Plan:
- DIM=4, engine model = 2x2 multiplier with N=3. A = identity, B[i][j] = 4i+j+1 -> C == B; done exactly 33 cycles after accept; eng_start pulses exactly 8 times, each 1 cycle wide.
- A[i][j] = 4i+j+1, B all ones -> C rows = {10,10,10,10}, {26,...}, {42,...}, {58,...}.
- A and B all -128 -> every C element = 65536, which checks sign extension and width.
- Issue the same command twice without reloading -> the second C equals the first (no doubling). With cmd_valid held high, the second accept occurs the cycle after the first done.
- During busy: wr_en to A[0][0] = 99, cmd_valid high, a spurious eng_done while in ISSUE -> result unchanged, cmd_ready = 0 throughout, no extra operation counted.
- Pull rst_n low in WAIT of the 3rd operation -> busy = 0, eng_start = 0, cmd_ready = 1 and all rd_data = 0 immediately. A late eng_done after release has no effect; a fresh load + command then gives the correct C.

Source files
------------

// File: rtl/matmul_tile_ctrl.sv
// matmul_tile_ctrl: runs a DIM x DIM signed matrix product on one 2x2 engine.
// Host writes A/B (wr_*), issues cmd_valid, reads C (rd_*); engine on eng_*.
module matmul_tile_ctrl #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int DIM    = 4,
    parameter int IDX_W  = $clog2(DIM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [IDX_W-1:0]         wr_row,
    input  logic [IDX_W-1:0]         wr_col,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]         rd_row,
    input  logic [IDX_W-1:0]         rd_col,
    output logic [ACC_W-1:0]         rd_data,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     eng_start,
    output logic signed [DATA_W-1:0] eng_A [2][2],
    output logic signed [DATA_W-1:0] eng_B [2][2],
    input  logic signed [ACC_W-1:0]  eng_C [2][2],
    input  logic                     eng_done
);

    localparam int T  = DIM / 2;
    localparam int TW = (T > 1) ? $clog2(T) : 1;
    localparam logic [TW-1:0] TMAX = TW'(T - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic signed [DATA_W-1:0] a_q [DIM][DIM];
    logic signed [DATA_W-1:0] a_d [DIM][DIM];
    logic signed [DATA_W-1:0] b_q [DIM][DIM];
    logic signed [DATA_W-1:0] b_d [DIM][DIM];
    logic signed [ACC_W-1:0]  c_q [DIM][DIM];
    logic signed [ACC_W-1:0]  c_d [DIM][DIM];

    logic signed [DATA_W-1:0] eng_a_q [2][2];
    logic signed [DATA_W-1:0] eng_a_d [2][2];
    logic signed [DATA_W-1:0] eng_b_q [2][2];
    logic signed [DATA_W-1:0] eng_b_d [2][2];

    logic [TW-1:0] ti_q, ti_d;
    logic [TW-1:0] tj_q, tj_d;
    logic [TW-1:0] tk_q, tk_d;

    logic load;
    logic last;

    // Element index of row/column `off` inside tile `t`.
    function automatic logic [IDX_W-1:0] elem_idx(
        input logic [TW-1:0] t,
        input int            off
    );
        return IDX_W'(2 * int'(t) + off);
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        eng_a_d = eng_a_q;
        eng_b_d = eng_b_q;
        ti_d    = ti_q;
        tj_d    = tj_q;
        tk_d    = tk_q;
        load    = 1'b0;
        last    = 1'b0;

        if (state_q == S_IDLE && wr_en) begin
            if (wr_sel) begin
                b_d[wr_row][wr_col] = wr_data;
            end else begin
                a_d[wr_row][wr_col] = wr_data;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_ISSUE;
                    ti_d    = '0;
                    tj_d    = '0;
                    tk_d    = '0;
                    load    = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    // First K-tile overwrites so a previous run never leaks in.
                    for (int r = 0; r < 2; r++) begin
                        for (int c = 0; c < 2; c++) begin
                            if (tk_q == '0) begin
                                c_d[elem_idx(ti_q, r)][elem_idx(tj_q, c)] =
                                    eng_C[r][c];
                            end else begin
                                c_d[elem_idx(ti_q, r)][elem_idx(tj_q, c)] =
                                    c_q[elem_idx(ti_q, r)][elem_idx(tj_q, c)]
                                    + eng_C[r][c];
                            end
                        end
                    end
                    if (tk_q == TMAX) begin
                        tk_d = '0;
                        if (tj_q == TMAX) begin
                            tj_d = '0;
                            if (ti_q == TMAX) begin
                                last = 1'b1;
                            end else begin
                                ti_d = ti_q + 1'b1;
                            end
                        end else begin
                            tj_d = tj_q + 1'b1;
                        end
                    end else begin
                        tk_d = tk_q + 1'b1;
                    end
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        load    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Operands come from the post-write buffers so a write in the
        // accept cycle is seen by the command.
        if (load) begin
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    eng_a_d[r][c] = a_d[elem_idx(ti_d, r)][elem_idx(tk_d, c)];
                    eng_b_d[r][c] = b_d[elem_idx(tk_d, r)][elem_idx(tj_d, c)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ti_q    <= '0;
            tj_q    <= '0;
            tk_q    <= '0;
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                    c_q[r][c] <= '0;
                end
            end
            for (int r = 0; r < 2; r++) begin
                for (int c = 0; c < 2; c++) begin
                    eng_a_q[r][c] <= '0;
                    eng_b_q[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            ti_q    <= ti_d;
            tj_q    <= tj_d;
            tk_q    <= tk_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            eng_a_q <= eng_a_d;
            eng_b_q <= eng_b_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign eng_start = (state_q == S_ISSUE);
    assign eng_A     = eng_a_q;
    assign eng_B     = eng_b_q;
    assign rd_data   = c_q[rd_row][rd_col];

endmodule

// File: tb/tb_matmul_tile_ctrl.sv
// tb_matmul_tile_ctrl: directed table, random rounds and corner sequences
// for matmul_tile_ctrl with a behavioural 2x2 engine and full-matrix model.
module tb_matmul_tile_ctrl;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_en = 1'b0;
    logic wr_sel = 1'b0;
    logic [1:0] wr_row = '0;
    logic [1:0] wr_col = '0;
    logic signed [7:0] wr_data = '0;
    logic [1:0] rd_row = '0;
    logic [1:0] rd_col = '0;
    logic [31:0] rd_data;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic busy;
    logic done;
    logic eng_start;
    logic signed [7:0] eng_A [2][2];
    logic signed [7:0] eng_B [2][2];
    logic signed [31:0] eng_C [2][2];
    logic eng_done;

    matmul_tile_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .busy(busy), .done(done),
        .eng_start(eng_start), .eng_A(eng_A), .eng_B(eng_B),
        .eng_C(eng_C), .eng_done(eng_done)
    );

    always #5 clk = ~clk;

    // Engine: answers N cycles after the cycle it saw eng_start.
    int eng_n = 3;
    int cnt = 0;
    int start_cnt = 0;
    bit prev_start = 1'b0;
    bit start_wide = 1'b0;
    logic mdl_done = 1'b0;
    logic spur_done = 1'b0;
    logic signed [31:0] pend [2][2];
    assign eng_done = mdl_done | spur_done;

    always @(negedge clk) begin
        mdl_done = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                mdl_done = 1'b1;
                eng_C = pend;
            end
        end
        if (eng_start) begin
            if (prev_start) start_wide = 1'b1;
            start_cnt++;
            cnt = eng_n;
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    pend[i][j] = int'(eng_A[i][0]) * int'(eng_B[0][j])
                               + int'(eng_A[i][1]) * int'(eng_B[1][j]);
        end
        prev_start = eng_start;
    end

    int checks = 0;
    int failures = 0;
    int ref_a [D][D];
    int ref_b [D][D];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int val(input int mode, input int i, input int j);
        case (mode)
            0: return (i == j) ? 1 : 0;
            1: return 4 * i + j + 1;
            2: return 1;
            3: return -128;
            default: return int'($urandom_range(255)) - 128;
        endcase
    endfunction

    task automatic wr(input bit sel, input int r, input int c, input int v);
        @(negedge clk);
        wr_en = 1'b1;
        wr_sel = sel;
        wr_row = r[1:0];
        wr_col = c[1:0];
        wr_data = v[7:0];
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_all(input int amode, input int bmode);
        int v;
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) begin
                v = val(amode, i, j);
                ref_a[i][j] = v;
                wr(1'b0, i, j, v);
                v = val(bmode, i, j);
                ref_b[i][j] = v;
                wr(1'b1, i, j, v);
            end
    endtask

    task automatic check_c(input string tag);
        int s;
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) begin
                s = 0;
                for (int k = 0; k < D; k++)
                    s += ref_a[i][k] * ref_b[k][j];
                rd_row = i[1:0];
                rd_col = j[1:0];
                #1;
                chk($sformatf("%s C[%0d][%0d]", tag, i, j),
                    $signed(rd_data), s);
            end
    endtask

    task automatic read_c(input int i, input int j, output int v);
        rd_row = i[1:0];
        rd_col = j[1:0];
        #1;
        v = $signed(rd_data);
    endtask

    task automatic run_cmd(input string tag, input bit disturb,
                           input bit same_wr, input int wr_r,
                           input int wr_c, input int wr_v);
        int lat;
        int s0;
        bit bad;
        @(negedge clk);
        chk({tag, " ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        if (same_wr) begin
            wr_en = 1'b1;
            wr_sel = 1'b0;
            wr_row = wr_r[1:0];
            wr_col = wr_c[1:0];
            wr_data = wr_v[7:0];
            ref_a[wr_r][wr_c] = wr_v;
        end
        s0 = start_cnt;
        lat = 0;
        bad = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!busy || cmd_ready) bad = 1'b1;
            if (disturb) begin
                cmd_valid = 1'b1;
                wr_en = 1'b1;
                wr_sel = 1'b0;
                wr_row = '0;
                wr_col = '0;
                wr_data = 8'sd99;
                spur_done = eng_start;
            end else begin
                cmd_valid = 1'b0;
                wr_en = 1'b0;
            end
        end while (!done && lat < 2000);
        cmd_valid = 1'b0;
        wr_en = 1'b0;
        spur_done = 1'b0;
        chk({tag, " latency"}, lat, 8 * (eng_n + 1) + 1);
        chk({tag, " starts"}, start_cnt - s0, 8);
        chk({tag, " busy/ready"}, int'(bad), 0);
        @(negedge clk);
        chk({tag, " done pulse"}, done, 0);
        chk({tag, " idle"}, cmd_ready, 1);
        check_c(tag);
    endtask

    typedef struct {
        int amode;
        int bmode;
        int exp00;
        int exp33;
    } vec_t;

    vec_t vecs [3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int v;
        int k;
        int s0;

        vecs[0] = '{amode: 0, bmode: 1, exp00: 1, exp33: 16};
        vecs[1] = '{amode: 1, bmode: 2, exp00: 10, exp33: 58};
        vecs[2] = '{amode: 3, bmode: 3, exp00: 65536, exp33: 65536};

        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) begin
                ref_a[i][j] = 0;
                ref_b[i][j] = 0;
            end

        // Reset state.
        #12;
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst eng_start", eng_start, 0);
        chk("rst eng_A", eng_A[0][0], 0);
        chk("rst eng_B", eng_B[1][1], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_c("rst");

        // Directed table.
        for (int t = 0; t < 3; t++) begin
            load_all(vecs[t].amode, vecs[t].bmode);
            run_cmd($sformatf("vec%0d", t), 1'b0, 1'b0, 0, 0, 0);
            read_c(0, 0, v);
            chk($sformatf("vec%0d c00", t), v, vecs[t].exp00);
            read_c(3, 3, v);
            chk($sformatf("vec%0d c33", t), v, vecs[t].exp33);
        end
        chk("start width", int'(start_wide), 0);

        // Back-to-back with cmd_valid held: no doubling.
        load_all(1, 1);
        @(negedge clk);
        cmd_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 2000);
        chk("b2b lat1", lat, 33);
        @(negedge clk);
        chk("b2b accept ready", cmd_ready, 1);
        @(negedge clk);
        chk("b2b busy", busy, 1);
        chk("b2b start", eng_start, 1);
        cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 2000);
        chk("b2b lat2", lat, 32);
        @(negedge clk);
        check_c("b2b");

        // Writes, commands and a stray eng_done while busy.
        run_cmd("disturb", 1'b1, 1'b0, 0, 0, 0);

        // Random data, engine latency and same-cycle write.
        for (int r = 0; r < 4; r++) begin
            eng_n = int'($urandom_range(1, 4));
            load_all(4, 4);
            run_cmd($sformatf("rnd%0d", r), 1'b0, 1'($urandom_range(1)),
                    int'($urandom_range(3)), int'($urandom_range(3)),
                    int'($urandom_range(255)) - 128);
        end

        // Reset in WAIT of the third operation.
        eng_n = 3;
        load_all(1, 4);
        @(negedge clk);
        cmd_valid = 1'b1;
        k = 0;
        lat = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            lat++;
            if (eng_start) k++;
        end while (k < 3 && lat < 2000);
        chk("abort reached op3", k, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort start", eng_start, 0);
        chk("abort ready", cmd_ready, 1);
        for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) begin
                ref_a[i][j] = 0;
                ref_b[i][j] = 0;
            end
        check_c("abort");
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_cnt;
        repeat (6) @(negedge clk);
        chk("late done busy", busy, 0);
        chk("late done starts", start_cnt - s0, 0);
        check_c("late done");
        load_all(2, 1);
        run_cmd("post abort", 1'b0, 1'b0, 0, 0, 0);
        chk("start width end", int'(start_wide), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
